// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Timing and control unit for a basic-computer datapath. Steps a
//            T0..T6 sequence counter and decodes the datapath strobes.
// Revision : 1.0
// ============================================================================
module control_sequencer #(
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instruction,
  input  logic        E_carryout,
  input  logic        ac_zero,
  input  logic        ac_neg,
  input  logic        dr_zero,
  output logic [2:0]  bus_selects,
  output logic [2:0]  op_select,
  output logic        load_ar,
  output logic        increment_ar,
  output logic        load_pc,
  output logic        increment_pc,
  output logic        load_ir,
  output logic        load_dr,
  output logic        increment_dr,
  output logic        load_ac,
  output logic        reset_ac,
  output logic        increment_ac,
  output logic        load_co,
  output logic        reset_co,
  output logic        increment_co,
  output logic        write_enable,
  output logic [3:0]  sc,
  output logic        halted,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam state_t RESET_STATE = START_ON_RESET ? ST_RUN : ST_IDLE;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [2:0] ALU_AND     = 3'b000;
  localparam logic [2:0] ALU_ADD     = 3'b001;
  localparam logic [2:0] ALU_PASS_DR = 3'b010;
  localparam logic [2:0] ALU_CMA     = 3'b011;
  localparam logic [2:0] ALU_CIR     = 3'b100;
  localparam logic [2:0] ALU_CIL     = 3'b101;

  localparam logic [2:0] OPC_AND = 3'd0;
  localparam logic [2:0] OPC_ADD = 3'd1;
  localparam logic [2:0] OPC_LDA = 3'd2;
  localparam logic [2:0] OPC_STA = 3'd3;
  localparam logic [2:0] OPC_BUN = 3'd4;
  localparam logic [2:0] OPC_BSA = 3'd5;
  localparam logic [2:0] OPC_ISZ = 3'd6;
  localparam logic [2:0] OPC_REG = 3'd7;

  localparam logic [3:0] T0 = 4'd0;
  localparam logic [3:0] T1 = 4'd1;
  localparam logic [3:0] T2 = 4'd2;
  localparam logic [3:0] T3 = 4'd3;
  localparam logic [3:0] T4 = 4'd4;
  localparam logic [3:0] T5 = 4'd5;
  localparam logic [3:0] T6 = 4'd6;

  state_t      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic        i_q, i_d;
  logic [2:0]  opcode;

  assign opcode = instruction[14:12];
  assign sc     = sc_q;
  assign busy   = (state_q == ST_RUN);
  assign halted = (state_q == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      sc_q    <= T0;
      i_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      i_q     <= i_d;
    end
  end

  // Reset masks the whole decode so no strobe fires in the cycle reset is seen.
  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    i_d          = i_q;
    bus_selects  = BUS_NONE;
    op_select    = ALU_AND;
    load_ar      = 1'b0;
    increment_ar = 1'b0;
    load_pc      = 1'b0;
    increment_pc = 1'b0;
    load_ir      = 1'b0;
    load_dr      = 1'b0;
    increment_dr = 1'b0;
    load_ac      = 1'b0;
    reset_ac     = 1'b0;
    increment_ac = 1'b0;
    load_co      = 1'b0;
    reset_co     = 1'b0;
    increment_co = 1'b0;
    write_enable = 1'b0;

    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          sc_d = T0;
          if (start) begin
            state_d = ST_RUN;
          end
        end

        ST_HALT: begin
          sc_d = T0;
        end

        ST_RUN: begin
          sc_d = sc_q + 4'd1;
          case (sc_q)
            T0: begin
              bus_selects = BUS_PC;
              load_ar     = 1'b1;
            end
            T1: begin
              bus_selects  = BUS_MEM;
              load_ir      = 1'b1;
              increment_pc = 1'b1;
            end
            T2: begin
              bus_selects = BUS_IR;
              load_ar     = 1'b1;
              i_d         = instruction[15];
            end
            T3: begin
              if (opcode == OPC_REG) begin
                sc_d = T0;
                // Register-reference: only the most significant set bit acts.
                if (!i_q) begin
                  casez (instruction[11:0])
                    12'b1???_????_????: reset_ac = 1'b1;
                    12'b01??_????_????: reset_co = 1'b1;
                    12'b001?_????_????: begin
                      op_select = ALU_CMA;
                      load_ac   = 1'b1;
                    end
                    12'b0001_????_????: increment_co = 1'b1;
                    12'b0000_1???_????: begin
                      op_select = ALU_CIR;
                      load_ac   = 1'b1;
                      load_co   = 1'b1;
                    end
                    12'b0000_01??_????: begin
                      op_select = ALU_CIL;
                      load_ac   = 1'b1;
                      load_co   = 1'b1;
                    end
                    12'b0000_001?_????: increment_ac = 1'b1;
                    12'b0000_0001_????: increment_pc = ~ac_neg;
                    12'b0000_0000_1???: increment_pc = ac_neg;
                    12'b0000_0000_01??: increment_pc = ac_zero;
                    12'b0000_0000_001?: increment_pc = ~E_carryout;
                    12'b0000_0000_0001: state_d = ST_HALT;
                    default: begin
                    end
                  endcase
                end
              end else if (i_q) begin
                bus_selects = BUS_MEM;
                load_ar     = 1'b1;
              end
            end
            T4: begin
              case (opcode)
                OPC_AND, OPC_ADD, OPC_LDA, OPC_ISZ: begin
                  bus_selects = BUS_MEM;
                  load_dr     = 1'b1;
                end
                OPC_STA: begin
                  bus_selects  = BUS_AC;
                  write_enable = 1'b1;
                  sc_d         = T0;
                end
                OPC_BUN: begin
                  bus_selects = BUS_AR;
                  load_pc     = 1'b1;
                  sc_d        = T0;
                end
                OPC_BSA: begin
                  bus_selects  = BUS_PC;
                  write_enable = 1'b1;
                  increment_ar = 1'b1;
                end
                default: sc_d = T0;
              endcase
            end
            T5: begin
              sc_d = T0;
              case (opcode)
                OPC_AND: begin
                  op_select = ALU_AND;
                  load_ac   = 1'b1;
                end
                OPC_ADD: begin
                  op_select = ALU_ADD;
                  load_ac   = 1'b1;
                  load_co   = 1'b1;
                end
                OPC_LDA: begin
                  op_select = ALU_PASS_DR;
                  load_ac   = 1'b1;
                end
                OPC_BSA: begin
                  bus_selects = BUS_AR;
                  load_pc     = 1'b1;
                end
                OPC_ISZ: begin
                  increment_dr = 1'b1;
                  sc_d         = T6;
                end
                default: begin
                end
              endcase
            end
            T6: begin
              sc_d = T0;
              if (opcode == OPC_ISZ) begin
                bus_selects  = BUS_DR;
                write_enable = 1'b1;
                increment_pc = dr_zero;
              end
            end
            default: sc_d = T0;
          endcase
        end

        default: begin
          state_d = ST_IDLE;
          sc_d    = T0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Scoreboard bench for control_sequencer with a small behavioural
//            datapath closing the loop through IR, AC, DR, E and memory.
// Revision : 1.0
// ============================================================================
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instruction;
  logic        E_carryout, ac_zero, ac_neg, dr_zero;
  logic [2:0]  bus_selects, op_select;
  logic        load_ar, increment_ar, load_pc, increment_pc, load_ir, load_dr;
  logic        increment_dr, load_ac, reset_ac, increment_ac, load_co, reset_co;
  logic        increment_co, write_enable;
  logic [3:0]  sc;
  logic        halted, busy;

  always #5 clk = ~clk;

  control_sequencer #(.START_ON_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction),
    .E_carryout(E_carryout), .ac_zero(ac_zero), .ac_neg(ac_neg), .dr_zero(dr_zero),
    .bus_selects(bus_selects), .op_select(op_select),
    .load_ar(load_ar), .increment_ar(increment_ar), .load_pc(load_pc),
    .increment_pc(increment_pc), .load_ir(load_ir), .load_dr(load_dr),
    .increment_dr(increment_dr), .load_ac(load_ac), .reset_ac(reset_ac),
    .increment_ac(increment_ac), .load_co(load_co), .reset_co(reset_co),
    .increment_co(increment_co), .write_enable(write_enable),
    .sc(sc), .halted(halted), .busy(busy)
  );

  localparam logic [13:0] LAR = 14'h2000, IAR = 14'h1000, LPC = 14'h0800, IPC = 14'h0400;
  localparam logic [13:0] LIR = 14'h0200, LDR = 14'h0100, IDR = 14'h0080, LAC = 14'h0040;
  localparam logic [13:0] RAC = 14'h0020, IAC = 14'h0010, LCO = 14'h0008, RCO = 14'h0004;
  localparam logic [13:0] ICO = 14'h0002, WE  = 14'h0001, NONE = 14'h0000;

  typedef struct packed {
    logic [3:0]  sc;
    logic [2:0]  bus;
    logic [2:0]  op;
    logic [13:0] strb;
  } vec_t;

  logic [13:0] act_strb;
  vec_t        act_v;
  assign act_strb = {load_ar, increment_ar, load_pc, increment_pc, load_ir, load_dr,
                     increment_dr, load_ac, reset_ac, increment_ac, load_co, reset_co,
                     increment_co, write_enable};
  assign act_v = {sc, bus_selects, op_select, act_strb};

  // Behavioural datapath driven by the strobes.
  logic [15:0] mem [0:4095];
  logic [11:0] ar, pc;
  logic [15:0] ir, dr, ac;
  logic        e;
  logic [15:0] bus_val, alu_val;
  logic        alu_e;
  logic        set_regs, pre_en;
  logic [11:0] set_pc, pre_addr;
  logic [15:0] set_ac, pre_data;
  logic        set_e;

  assign instruction = ir;
  assign ac_zero     = (ac == 16'h0000);
  assign ac_neg      = ac[15];
  assign dr_zero     = (dr == 16'h0000);
  assign E_carryout  = e;

  always_comb begin
    case (bus_selects)
      3'd1:    bus_val = {4'h0, ar};
      3'd2:    bus_val = {4'h0, pc};
      3'd3:    bus_val = dr;
      3'd4:    bus_val = ac;
      3'd5:    bus_val = ir;
      3'd7:    bus_val = mem[ar];
      default: bus_val = 16'h0000;
    endcase
  end

  always_comb begin
    alu_val = ac;
    alu_e   = e;
    case (op_select)
      3'd0: alu_val = ac & dr;
      3'd1: {alu_e, alu_val} = {1'b0, ac} + {1'b0, dr};
      3'd2: alu_val = dr;
      3'd3: alu_val = ~ac;
      3'd4: begin alu_val = {e, ac[15:1]}; alu_e = ac[0]; end
      3'd5: begin alu_val = {ac[14:0], e}; alu_e = ac[15]; end
      default: begin end
    endcase
  end

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (set_regs) begin
      pc <= set_pc; ac <= set_ac; e <= set_e;
      ar <= 12'h000; ir <= 16'h0000; dr <= 16'h0000;
    end else begin
      if (write_enable) mem[ar] <= bus_val;
      if (load_ar) ar <= bus_val[11:0];
      if (increment_ar) ar <= ar + 12'd1;
      if (load_pc) pc <= bus_val[11:0];
      if (increment_pc) pc <= pc + 12'd1;
      if (load_ir) ir <= bus_val;
      if (load_dr) dr <= bus_val;
      if (increment_dr) dr <= dr + 16'd1;
      if (load_ac) ac <= alu_val;
      if (load_co) e <= alu_e;
      if (reset_ac) ac <= 16'h0000;
      if (increment_ac) ac <= ac + 16'd1;
      if (reset_co) e <= 1'b0;
      if (increment_co) e <= ~e;
    end
  end

  int    errors = 0;
  int    checks = 0;
  vec_t  exp_q[$];
  vec_t  exp_v;
  string cur = "init";

  // Monitor: every active cycle of the sequencer must match the next expected step.
  always @(negedge clk) begin
    if (!reset && busy) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL %s unexpected_step: got sc=%0d bus=%0d op=%0d strobes=%h, required no activity",
                 cur, sc, bus_selects, op_select, act_strb);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          errors = errors + 1;
          $display("FAIL %s step: got sc=%0d bus=%0d op=%0d strobes=%h, required sc=%0d bus=%0d op=%0d strobes=%h",
                   cur, sc, bus_selects, op_select, act_strb,
                   exp_v.sc, exp_v.bus, exp_v.op, exp_v.strb);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s %s: got %h, required %h", cur, nm, act, expv);
    end
  endtask

  function automatic void push(input logic [3:0] s, input logic [2:0] b,
                               input logic [2:0] o, input logic [13:0] m);
    vec_t v;
    v.sc = s; v.bus = b; v.op = o; v.strb = m;
    exp_q.push_back(v);
  endfunction

  function automatic void push_fetch();
    push(4'd0, 3'd2, 3'd0, LAR);
    push(4'd1, 3'd7, 3'd0, LIR | IPC);
    push(4'd2, 3'd5, 3'd0, LAR);
  endfunction

  task automatic setup(input logic [11:0] p, input logic [15:0] a, input logic e0);
    @(posedge clk); #1 set_pc = p; set_ac = a; set_e = e0; set_regs = 1'b1;
    @(posedge clk); #1 set_regs = 1'b0;
  endtask

  task automatic poke(input logic [11:0] addr, input logic [15:0] d);
    @(posedge clk); #1 pre_addr = addr; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1 pre_en = 1'b0;
  endtask

  // Pulse start, wait for the expected steps to drain, then reset on the next cycle.
  task automatic go(input bit hold, input logic [3:0] next_sc);
    int n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk); #2;
      n++;
    end
    chk("steps_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (!hold) begin
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("reset_cycle_outputs", 32'({bus_selects, op_select, act_strb}), 32'd0);
      chk("reset_cycle_sc", 32'(sc), 32'(next_sc));
      @(posedge clk); #1 reset = 1'b0;
      chk("post_reset_sc", 32'(sc), 32'd0);
      chk("post_reset_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic reg_ref(input string nm, input logic [11:0] p, input logic [15:0] instr,
                         input logic [15:0] a, input logic e0,
                         input logic [2:0] o, input logic [13:0] m);
    cur = nm;
    setup(p, a, e0);
    poke(p, instr);
    push_fetch();
    push(4'd3, 3'd0, o, m);
    go(1'b0, 4'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; set_regs = 1'b0; pre_en = 1'b0;
    set_pc = '0; set_ac = '0; set_e = 1'b0; pre_addr = '0; pre_data = '0;

    cur = "reset";
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("outputs_in_reset", 32'({bus_selects, op_select, act_strb}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("sc", 32'(sc), 32'd0);
    chk("busy", 32'(busy), 32'd0);
    chk("halted", 32'(halted), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_without_start", 32'({busy, sc}), 32'd0);

    reg_ref("cla", 12'h000, 16'h7800, 16'h1234, 1'b0, 3'd0, RAC);
    chk("ac", 32'(ac), 32'h0000);
    chk("pc", 32'(pc), 32'h001);

    reg_ref("cma_priority", 12'h080, 16'h7220, 16'h00FF, 1'b0, 3'd3, LAC);
    chk("ac", 32'(ac), 32'hFF00);

    reg_ref("cil", 12'h090, 16'h7040, 16'h8001, 1'b0, 3'd5, LAC | LCO);
    chk("ac", 32'(ac), 32'h0002);
    chk("e", 32'(e), 32'd1);

    reg_ref("cir", 12'h098, 16'h7080, 16'h0003, 1'b1, 3'd4, LAC | LCO);
    chk("ac", 32'(ac), 32'h8001);
    chk("e", 32'(e), 32'd1);

    reg_ref("sza_skip", 12'h0A0, 16'h7004, 16'h0000, 1'b0, 3'd0, IPC);
    chk("pc", 32'(pc), 32'h0A2);

    reg_ref("spa_noskip", 12'h0B0, 16'h7010, 16'h8000, 1'b0, 3'd0, NONE);
    chk("pc", 32'(pc), 32'h0B1);

    reg_ref("cme", 12'h0B8, 16'h7100, 16'h0000, 1'b0, 3'd0, ICO);
    chk("e", 32'(e), 32'd1);

    reg_ref("cle", 12'h0BC, 16'h7400, 16'h0000, 1'b1, 3'd0, RCO);
    chk("e", 32'(e), 32'd0);

    reg_ref("io_nop", 12'h0C8, 16'hF800, 16'h5555, 1'b0, 3'd0, NONE);
    chk("ac", 32'(ac), 32'h5555);

    cur = "add_direct";
    setup(12'h100, 16'h0004, 1'b0);
    poke(12'h100, 16'h1005);
    poke(12'h005, 16'h0003);
    push_fetch();
    push(4'd3, 3'd0, 3'd0, NONE);
    push(4'd4, 3'd7, 3'd0, LDR);
    push(4'd5, 3'd0, 3'd1, LAC | LCO);
    go(1'b0, 4'd0);
    chk("ac", 32'(ac), 32'h0007);
    chk("e", 32'(e), 32'd0);

    cur = "and_indirect";
    setup(12'h0C0, 16'h0F3C, 1'b0);
    poke(12'h0C0, 16'h8010);
    poke(12'h010, 16'h0020);
    poke(12'h020, 16'h00F0);
    push_fetch();
    push(4'd3, 3'd7, 3'd0, LAR);
    push(4'd4, 3'd7, 3'd0, LDR);
    push(4'd5, 3'd0, 3'd0, LAC);
    go(1'b0, 4'd0);
    chk("ar", 32'(ar), 32'h020);
    chk("ac", 32'(ac), 32'h0030);

    cur = "sta";
    setup(12'h110, 16'hBEEF, 1'b0);
    poke(12'h110, 16'h3050);
    push_fetch();
    push(4'd3, 3'd0, 3'd0, NONE);
    push(4'd4, 3'd4, 3'd0, WE);
    go(1'b0, 4'd0);
    chk("mem50", 32'(mem[12'h050]), 32'hBEEF);

    cur = "sta_reset_at_t4";
    setup(12'h120, 16'hCAFE, 1'b0);
    poke(12'h120, 16'h3051);
    poke(12'h051, 16'h1111);
    push_fetch();
    push(4'd3, 3'd0, 3'd0, NONE);
    go(1'b0, 4'd4);
    chk("mem51", 32'(mem[12'h051]), 32'h1111);

    cur = "bun";
    setup(12'h130, 16'h0000, 1'b0);
    poke(12'h130, 16'h4123);
    push_fetch();
    push(4'd3, 3'd0, 3'd0, NONE);
    push(4'd4, 3'd1, 3'd0, LPC);
    go(1'b0, 4'd0);
    chk("pc", 32'(pc), 32'h123);

    cur = "bsa";
    setup(12'h140, 16'h0000, 1'b0);
    poke(12'h140, 16'h5200);
    push_fetch();
    push(4'd3, 3'd0, 3'd0, NONE);
    push(4'd4, 3'd2, 3'd0, WE | IAR);
    push(4'd5, 3'd1, 3'd0, LPC);
    go(1'b0, 4'd0);
    chk("mem200", 32'(mem[12'h200]), 32'h0141);
    chk("pc", 32'(pc), 32'h201);

    cur = "isz";
    setup(12'h150, 16'h0000, 1'b0);
    poke(12'h150, 16'h6030);
    poke(12'h030, 16'hFFFF);
    push_fetch();
    push(4'd3, 3'd0, 3'd0, NONE);
    push(4'd4, 3'd7, 3'd0, LDR);
    push(4'd5, 3'd0, 3'd0, IDR);
    push(4'd6, 3'd3, 3'd0, WE | IPC);
    go(1'b0, 4'd0);
    chk("mem30", 32'(mem[12'h030]), 32'h0000);
    chk("pc", 32'(pc), 32'h152);

    cur = "hlt";
    setup(12'h160, 16'h0000, 1'b0);
    poke(12'h160, 16'h7001);
    push_fetch();
    push(4'd3, 3'd0, 3'd0, NONE);
    go(1'b1, 4'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("halted", 32'(halted), 32'd1);
    chk("busy", 32'(busy), 32'd0);
    chk("outputs", 32'({bus_selects, op_select, act_strb}), 32'd0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("halted_after_start", 32'(halted), 32'd1);
    chk("busy_after_start", 32'({busy, sc}), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("halted_after_reset", 32'(halted), 32'd0);
    chk("busy_after_reset", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: START_ON_RESET, default 0; when 1, the sequencer leaves IDLE on the first cycle after reset without waiting for start.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; in IDLE, begins fetch at the next edge.
REQ-005 instruction  in  16  current IR contents.
REQ-006 E_carryout, ac_zero, ac_neg, dr_zero  in  1 each  datapath flags: E, AC==0, AC[15], DR==0.
REQ-007 bus_selects  out  3  bus source: 1=AR, 2=PC, 3=DR, 4=AC, 5=IR, 6=TR, 7=MEM, 0=none.
REQ-008 op_select  out  3  ALU operation: 000 AND, 001 ADD, 010 pass DR, 011 complement AC, 100 CIR, 101 CIL.
REQ-009 load_ar, increment_ar, load_pc, increment_pc, load_ir, load_dr, increment_dr, load_ac, reset_ac, increment_ac, load_co, reset_co, increment_co, write_enable  out  1 each  datapath strobes; increment_co complements E.
REQ-010 sc  out  4  sequence counter T0..T6; halted  out  1; busy  out  1.

Function
REQ-011 States: IDLE, RUN, HALT; sc advances +1 per cycle in RUN and clears to 0 at the end of each instruction.
REQ-012 Strobes are combinational decodes of (state, sc, IR, I flag, inputs); in IDLE/HALT every strobe SHALL be 0 and bus_selects 000.
REQ-013 T0: bus_selects=2, load_ar=1.
REQ-014 T1: bus_selects=7, load_ir=1, increment_pc=1.
REQ-015 T2: bus_selects=5, load_ar=1 (AR<-IR[11:0]); register I latches instruction[15].
REQ-016 T3, opcode IR[14:12]=111, I=0: register-reference; exactly one bit of IR[11:0] is honoured, priority MSB first: CLA reset_ac; CLE reset_co; CMA op 011 load_ac; CME increment_co; CIR op 100 load_ac load_co; CIL op 101 load_ac load_co; INC increment_ac; SPA/SNA/SZA/SZE increment_pc when AC[15]=0 / AC[15]=1 / ac_zero=1 / E_carryout=0; HLT enters HALT; then sc clears.
REQ-017 T3, opcode 111, I=1 (I/O): no strobes; sc clears.
REQ-018 T3, opcode 000-110: if I=1, bus_selects=7 and load_ar=1 (indirect); if I=0, no strobes.
REQ-019 AND/ADD/LDA: T4 bus_selects=7, load_dr; T5 load_ac with op 000/001/010; ADD also asserts load_co; sc clears after T5.
REQ-020 STA: T4 bus_selects=4, write_enable; sc clears.
REQ-021 BUN: T4 bus_selects=1, load_pc; sc clears.
REQ-022 BSA: T4 bus_selects=2, write_enable, increment_ar; T5 bus_selects=1, load_pc; sc clears.
REQ-023 ISZ: T4 bus_selects=7, load_dr; T5 increment_dr; T6 bus_selects=3, write_enable, and increment_pc when dr_zero=1; sc clears.
REQ-024 At most one bus source per cycle; write_enable is never asserted with bus_selects=7.
REQ-025 busy=1 only in RUN; halted=1 only in HALT; start is ignored in RUN and HALT.
REQ-026 sc never exceeds 6; an undefined sc value forces sc to 0.

Reset
REQ-027 reset (any state, any sc, including mid-instruction) SHALL force IDLE (or RUN with sc=0 when START_ON_RESET=1), sc=0, I=0, halted=0, and all strobes to 0 in the same cycle that reset is sampled.
REQ-028 The sequencer SHALL NOT assert any datapath reset strobe because of reset; datapath registers are reset by their own ports.

Verification
REQ-029 reset, then start pulse, IR=0x7800 (CLA) -> T0..T3 sequence; reset_ac=1 at T3; sc returns to 0; total 4 cycles.
REQ-030 IR=0x1005 (ADD direct), M[5]=0x0003, AC=0x0004 -> T5 shows op 001 with load_ac=1 and load_co=1; AC=0x0007; 6 cycles.
REQ-031 IR=0x8010 (AND indirect), M[0x010]=0x020 -> at T3 bus_selects=7 and load_ar=1; AR=0x020 before T4.
REQ-032 IR=0x6030 (ISZ), M[0x030]=0xFFFF -> T6 write_enable=1, increment_pc=1, stored 0x0000; PC skips by 2 in total.
REQ-033 IR=0x7001 (HLT) -> halted=1, busy=0, all strobes 0; a subsequent start pulse is ignored; reset returns to IDLE.
REQ-034 reset asserted at T4 of STA -> write_enable=0 that cycle; sc=0; memory unchanged.
